tdc_meas_sequencer: RTL



---
 rtl/tdc_pkg.sv | 17 +
 rtl/tdc_stat_acc.sv | 63 ++++++
 rtl/tdc_meas_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared types and sizing constants for the TDC measurement sequencer.
package tdc_pkg;

    localparam int unsigned HW_W      = 7;
    localparam int unsigned LOG2N_MAX = 7;
    localparam int unsigned ACC_W     = HW_W + LOG2N_MAX;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/tdc_stat_acc.sv
// Sample statistics: running sum, min, max and count, plus next-cycle views
// of the reportable results so the sequencer can latch them on completion.
module tdc_stat_acc #(
    parameter int unsigned HW_W  = tdc_pkg::HW_W,
    parameter int unsigned ACC_W = tdc_pkg::ACC_W,
    parameter int unsigned CNT_W = tdc_pkg::CNT_W
) (
    input  logic             clk_launch,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             acc,
    input  logic [2:0]       log2n,
    input  logic [HW_W-1:0]  hw,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic [HW_W-1:0]  mean_nxt,
    output logic [HW_W-1:0]  min_nxt,
    output logic [HW_W-1:0]  max_nxt
);

    logic [ACC_W-1:0] sum_q, sum_d;
    logic [HW_W-1:0]  min_q, min_d;
    logic [HW_W-1:0]  max_q, max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear on burst start, fold in one sample per accepted capture.
    always_comb begin
        sum_d = sum_q;
        min_d = min_q;
        max_d = max_q;
        cnt_d = cnt_q;
        if (clr) begin
            sum_d = '0;
            min_d = '1;
            max_d = '0;
            cnt_d = '0;
        end else if (acc) begin
            sum_d = sum_q + ACC_W'(hw);
            min_d = (hw < min_q) ? hw : min_q;
            max_d = (hw > max_q) ? hw : max_q;
            cnt_d = cnt_q + CNT_W'(1);
        end
        cnt_nxt  = cnt_d;
        mean_nxt = HW_W'(sum_d >> log2n);
        min_nxt  = (cnt_d == '0) ? '0 : min_d;
        max_nxt  = (cnt_d == '0) ? '0 : max_d;
    end

    // Accumulator registers.
    always_ff @(posedge clk_launch) begin
        if (!rst_n) begin
            sum_q <= '0;
            min_q <= '1;
            max_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            min_q <= min_d;
            max_q <= max_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tdc_meas_sequencer.sv
// Counted-burst launch sequencer for the TDC: settles, launches one pg edge,
// waits for the capture, repeats 2^n times and reports mean/min/max.
module tdc_meas_sequencer #(
    parameter int unsigned HW_W       = tdc_pkg::HW_W,
    parameter int unsigned LOG2N_MAX  = tdc_pkg::LOG2N_MAX,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic            clk_launch,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [2:0]      cfg_log2n,
    input  logic [HW_W-1:0] tdc_hw,
    input  logic            tdc_val_out,
    output logic            tdc_pg,
    output logic            tdc_val_in,
    output logic            busy,
    output logic            done,
    output logic            timeout_err,
    output logic [HW_W-1:0] res_mean,
    output logic [HW_W-1:0] res_min,
    output logic [HW_W-1:0] res_max,
    output logic [7:0]      res_cnt
);
    import tdc_pkg::*;

    localparam int unsigned SUM_W = HW_W + LOG2N_MAX;
    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [2:0]       n_q, n_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pg_q, pg_d;
    logic             val_in_q, val_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             to_q, to_d;
    logic [HW_W-1:0]  mean_q, mean_d;
    logic [HW_W-1:0]  min_q, min_d;
    logic [HW_W-1:0]  max_q, max_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             acc_clr, acc_en, hit_to;
    logic [7:0]       burst_len;
    logic [7:0]       cnt_nxt;
    logic [HW_W-1:0]  mean_nxt, min_nxt, max_nxt;

    tdc_stat_acc #(
        .HW_W  (HW_W),
        .ACC_W (SUM_W),
        .CNT_W (8)
    ) u_acc (
        .clk_launch (clk_launch),
        .rst_n      (rst_n),
        .clr        (acc_clr),
        .acc        (acc_en),
        .log2n      (n_q),
        .hw         (tdc_hw),
        .cnt_nxt    (cnt_nxt),
        .mean_nxt   (mean_nxt),
        .min_nxt    (min_nxt),
        .max_nxt    (max_nxt)
    );

    // Accumulator control; kept apart from the FSM so the completion test
    // can use the post-accumulate count without a combinational cycle.
    always_comb begin
        acc_clr = (state_q == ST_IDLE) && start;
        acc_en  = (state_q == ST_WAIT) && tdc_val_out && !abort;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        settle_d  = settle_q;
        timer_d   = timer_q;
        pg_d      = pg_q;
        to_d      = to_q;
        mean_d    = mean_q;
        min_d     = min_q;
        max_d     = max_q;
        cnt_d     = cnt_q;
        hit_to    = 1'b0;
        burst_len = 8'd1 << n_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d      = cfg_log2n;
                    settle_d = '0;
                    to_d     = 1'b0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_LAUNCH;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_LAUNCH: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tdc_val_out) begin
                    if (cnt_nxt == burst_len) begin
                        state_d = ST_DONE;
                    end else begin
                        settle_d = '0;
                        state_d  = ST_SETTLE;
                    end
                end else if (timer_q == TMR_LAST) begin
                    hit_to  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides any in-flight transition, including a final sample.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            hit_to  = 1'b0;
        end

        // Outputs are registered, so they are derived from the next state.
        busy_d   = (state_d != ST_IDLE);
        val_in_d = (state_d == ST_LAUNCH);
        done_d   = (state_d == ST_DONE);
        if (state_d == ST_LAUNCH) begin
            pg_d = ~pg_q;
        end
        if (state_d == ST_DONE) begin
            to_d   = hit_to;
            mean_d = hit_to ? '0 : mean_nxt;
            min_d  = min_nxt;
            max_d  = max_nxt;
            cnt_d  = cnt_nxt;
        end
    end

    // FSM state, timers and output registers.
    always_ff @(posedge clk_launch) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            settle_q <= '0;
            timer_q  <= '0;
            pg_q     <= 1'b0;
            val_in_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            to_q     <= 1'b0;
            mean_q   <= '0;
            min_q    <= '0;
            max_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            settle_q <= settle_d;
            timer_q  <= timer_d;
            pg_q     <= pg_d;
            val_in_q <= val_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            to_q     <= to_d;
            mean_q   <= mean_d;
            min_q    <= min_d;
            max_q    <= max_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        tdc_pg      = pg_q;
        tdc_val_in  = val_in_q;
        busy        = busy_q;
        done        = done_q;
        timeout_err = to_q;
        res_mean    = mean_q;
        res_min     = min_q;
        res_max     = max_q;
        res_cnt     = cnt_q;
    end

endmodule
